sl_host_arbiter: RTL and testbench
==================================

# sl_host_arbiter

Host-side arbiter and response router for the same-latency (SL) interconnect tree. It shares the tree's single `host_req`/`host_res` root port among `N_MST` masters using round-robin arbitration with one grant per cycle. Because the tree returns every response exactly `LATENCY` cycles after the request, the block routes responses with a tag shift register instead of IDs on the bus. It sits between the masters and the tree's root port, and raises sticky errors when a response does not match the expected latency.

## Interface
- `N_MST`, 4: number of masters; must be ≥ 2.
- `LATENCY`, 16: cycles from `host_req.valid` at the tree root to the matching `host_res.valid`; must be ≥ 2.
- `IDW`, `$clog2(N_MST)`: width of the master index (derived, not overridden).

Ports:
- `clk` in 1: clock; single clock domain.
- `rst_n` in 1: reset; asynchronous, active-low.
- `mst_req[N_MST]` in SL_REQ: per-master request; held stable while `valid` is high and `mst_gnt` is low.
- `mst_gnt[N_MST]` out 1 each: accept strobe, one-hot or zero.
- `mst_res[N_MST]` out SL_RES: per-master response.
- `host_req` out SL_REQ: request to the tree root.
- `host_res` in SL_RES: response from the tree root.
- `err_unexp` out 1: sticky; a response arrived with no outstanding tag.
- `err_lost` out 1: sticky; a tag expired with no response.

## Operation
- Arbitration:
  - Combinational round-robin over the `mst_req[i].valid` bits, starting from `rr_ptr`.
  - The first valid master at or after `rr_ptr` gets `mst_gnt[i]=1`.
  - On a grant to master i, `rr_ptr` becomes (i+1) mod `N_MST`. With no grant, `rr_ptr` holds.
  - There is no backpressure from the tree, so one request is accepted every cycle whenever any master is valid.
- Issue:
  - `host_req` is registered. It loads the granted master's request with `valid=1`, or `valid=0` when there is no grant.
  - All other fields of `host_req` are don't-care when `valid=0`.
- Tag pipe:
  - A `LATENCY`-deep shift register of {`tv`, `id[IDW-1:0]`}.
  - Stage 0 loads {grant, granted index} on the same edge that loads `host_req`.
  - The entry that leaves the pipe in cycle c corresponds to the `host_req` presented at cycle c−`LATENCY`.
- Response routing, evaluated in the cycle the pipe output is valid:
  - If `host_res.valid` and the output `tv` are both high: register `host_res` into `mst_res[id]` with `valid=1`.
  - If `host_res.valid` is high and the output `tv` is low: drop the response and set `err_unexp`.
  - If the output `tv` is high and `host_res.valid` is low: set `err_lost`; no master response is produced.
  - Every `mst_res[j]` that is not targeted has `valid=0`.
- Error flags clear only on reset.

## Timing
- Reset (async assert, sync deassert by system) forces:
  - `rr_ptr=0`, all tag entries `tv=0`;
  - `host_req.valid=0`, all `mst_res[*].valid=0`;
  - `err_unexp=0`, `err_lost=0`;
  - other SL_REQ/SL_RES fields reset to 0.
- `mst_gnt` is combinational and valid in the same cycle as `mst_req.valid`. A master sees its grant in cycle t.
- `host_req.valid` is high in t+1. `host_res` is expected in t+1+`LATENCY`. `mst_res[i].valid` is high in t+2+`LATENCY`.
- Sustained throughput is 1 request/cycle. Tags never overflow because the pipe depth equals `LATENCY`.
- Reset mid-operation discards all in-flight tags. Late responses arriving after reset deassertion flag `err_unexp`; this is accepted behaviour, and software resets the tree together with this block.
- A grant and a response delivery in the same cycle are independent and both proceed.

## Structure
- SL_REQ and SL_RES (fields `valid`, `we`, `addr`, `wdata` / `valid`, `rdata`) stay in the shared SL package, along with the SL interconnect tree's latency constants. This block imports them.
- One natural sub-module, `sl_rr_arb`: a parameterised round-robin arbiter with request vector in, one-hot grant out, and internal pointer. The tag pipe and routing stay inline.

## Test plan
1. Reset with `LATENCY=16`, no requests → all outputs 0 for 40 cycles; no error flags.
2. Master 2 alone issues addr 0x40 at t=10 → `mst_gnt[2]` at 10; `host_req.valid` at 11. Bench returns `rdata=0xABCD` at 27 → `mst_res[2]` valid with 0xABCD at 28; other masters `valid=0`.
3. All 4 masters continuously valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; `host_req.valid` high for 8 consecutive cycles; responses routed back in the same order, one per cycle.
4. Masters 1 and 3 valid with `rr_ptr=2` → grant 3 first, then 1. `rr_ptr` is 2 after the grant to 1.
5. Bench injects `host_res.valid` at a cycle with no outstanding tag → response dropped; `err_unexp` rises the next cycle and stays high until reset. In a separate run, the bench withholds a response → `err_lost` is set.
6. `rst_n` asserted with 5 requests in flight, released 3 cycles later → no `mst_res.valid` from the flushed requests; `rr_ptr=0`. A new request completes normally after exactly `LATENCY`+2 cycles.

Source files
------------

// File: rtl/sl_host_arbiter_pkg.sv
// Shared SL interconnect types and constants: request/response payloads of the
// same-latency tree and its default round-trip latency.
package sl_host_arbiter_pkg;

   localparam int SL_AW      = 32;
   localparam int SL_DW      = 32;
   localparam int SL_LATENCY = 16;

   typedef struct packed {
      logic             valid;
      logic             we;
      logic [SL_AW-1:0] addr;
      logic [SL_DW-1:0] wdata;
   } sl_req_t;

   typedef struct packed {
      logic             valid;
      logic [SL_DW-1:0] rdata;
   } sl_res_t;

endpackage

// File: rtl/sl_host_arbiter_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past the winner and holds when idle.
module sl_rr_arb #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          gnt_vld_o
);

   logic [IW-1:0] ptr_q, ptr_d;

   // Search the request vector starting at the pointer, wrapping once.
   always_comb begin
      int unsigned idx;
      // NOTE: every output of a combinational block gets a default up front so
      // no path leaves it unassigned, which would otherwise infer a latch.
      idx       = 0;
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!gnt_vld_o && req_i[idx]) begin
            gnt_vld_o  = 1'b1;
            gnt_idx_o  = IW'(idx);
            gnt_o[idx] = 1'b1;
         end
      end
   end

   // Next pointer: one past the winner modulo N, or unchanged with no grant.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld_o) begin
         if (gnt_idx_o == IW'(N - 1)) ptr_d = '0;
         else                         ptr_d = gnt_idx_o + 1'b1;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of block ordering.
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/sl_host_arbiter.sv
// Host-side arbiter and response router for the same-latency SL tree.
// Requests from N_MST masters are serialised round-robin onto host_req; since
// the tree answers exactly LATENCY cycles later, a tag shift register records
// which master owns each slot and steers host_res back without bus IDs.
// N_MST >= 2 and LATENCY >= 2 are assumed.
module sl_host_arbiter
   import sl_host_arbiter_pkg::*;
#(
   parameter  int N_MST   = 4,
   parameter  int LATENCY = SL_LATENCY,
   localparam int IDW     = $clog2(N_MST)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  sl_req_t          mst_req [N_MST],
   output logic [N_MST-1:0] mst_gnt,
   output sl_res_t          mst_res [N_MST],
   output sl_req_t          host_req,
   input  sl_res_t          host_res,
   output logic             err_unexp,
   output logic             err_lost
);

   logic [N_MST-1:0] req_vld;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_vld;

   sl_req_t          host_req_q, host_req_d;
   logic [IDW-1:0]   issue_id_q;

   logic [LATENCY-1:0] tv_q;
   logic [IDW-1:0]     id_q [LATENCY];
   logic               tag_vld;
   logic [IDW-1:0]     tag_id;

   sl_res_t          mst_res_q [N_MST];
   sl_res_t          mst_res_d [N_MST];
   logic             err_unexp_q, err_lost_q;

   // Gather the per-master valid bits for the arbiter.
   always_comb begin
      for (int j = 0; j < N_MST; j++) req_vld[j] = mst_req[j].valid;
   end

   sl_rr_arb #(.N(N_MST)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_vld),
      .gnt_o     (mst_gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   // Issue: forward the winner's request, or drop valid and keep the payload.
   always_comb begin
      host_req_d       = host_req_q;
      host_req_d.valid = 1'b0;
      if (gnt_vld) begin
         host_req_d       = mst_req[gnt_idx];
         host_req_d.valid = 1'b1;
      end
   end

   // Registered request to the tree root and tag-valid shift chain. The chain
   // is fed from the issue register, so the tag leaving it in cycle c belongs
   // to the host_req presented in cycle c-LATENCY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_req_q <= '0;
         tv_q       <= '0;
      end else begin
         host_req_q <= host_req_d;
         tv_q       <= {tv_q[LATENCY-2:0], host_req_q.valid};
      end
   end

   // Master-index side of the tag pipe, travelling alongside tv_q.
   always_ff @(posedge clk) begin
      // NOTE: the index storage is deliberately not reset; each entry is
      // qualified by its tv bit, which is reset, so stale indices are harmless.
      issue_id_q <= gnt_idx;
      id_q[0]    <= issue_id_q;
      for (int k = 1; k < LATENCY; k++) id_q[k] <= id_q[k-1];
   end

   assign tag_vld = tv_q[LATENCY-1];
   assign tag_id  = id_q[LATENCY-1];

   // Routing: only the master owning the expiring tag sees a valid response.
   always_comb begin
      for (int j = 0; j < N_MST; j++) begin
         mst_res_d[j] = '0;
         if (host_res.valid && tag_vld && (tag_id == IDW'(j))) mst_res_d[j] = host_res;
      end
   end

   // Response registers and sticky latency-mismatch flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < N_MST; j++) mst_res_q[j] <= '0;
         err_unexp_q <= 1'b0;
         err_lost_q  <= 1'b0;
      end else begin
         for (int j = 0; j < N_MST; j++) mst_res_q[j] <= mst_res_d[j];
         err_unexp_q <= err_unexp_q | (host_res.valid & ~tag_vld);
         err_lost_q  <= err_lost_q  | (tag_vld & ~host_res.valid);
      end
   end

   assign host_req  = host_req_q;
   assign mst_res   = mst_res_q;
   assign err_unexp = err_unexp_q;
   assign err_lost  = err_lost_q;

endmodule

// File: tb/tb_sl_host_arbiter.sv
// Self-checking bench for sl_host_arbiter. The bench plays the masters and the
// SL tree; a cycle-indexed reference model derives grants, host_req contents,
// routed responses and error flags from the arbitration/latency rules.
module tb_sl_host_arbiter;
   import sl_host_arbiter_pkg::*;

   localparam int N = 4;
   localparam int L = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   sl_req_t      mst_req [N];
   logic [N-1:0] mst_gnt;
   sl_res_t      mst_res [N];
   sl_req_t      host_req;
   sl_res_t      host_res;
   logic         err_unexp, err_lost;

   sl_host_arbiter #(.N_MST(N), .LATENCY(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mst_req   (mst_req),
      .mst_gnt   (mst_gnt),
      .mst_res   (mst_res),
      .host_req  (host_req),
      .host_res  (host_res),
      .err_unexp (err_unexp),
      .err_lost  (err_lost)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state, indexed by absolute cycle number.
   int          cyc = 0;
   int          mdl_ptr = 0;
   bit          pend     [N];
   sl_req_t     pend_req [N];
   sl_req_t     issue_req [int];   // expected host_req in that cycle
   int          issue_id  [int];   // master owning that slot
   logic [31:0] tree_rdata [int];  // tree response scheduled for that cycle
   bit          withhold  = 1'b0;
   bit          inject_now = 1'b0;
   bit          exp_res_vld = 1'b0;
   int          exp_res_id  = 0;
   logic [31:0] exp_res_data = '0;
   bit          exp_unexp = 1'b0;
   bit          exp_lost  = 1'b0;
   int          gnt_log [$];
   int          t_mark;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic new_req(input int j, input logic [31:0] addr);
      pend[j]           = 1'b1;
      pend_req[j].valid = 1'b1;
      pend_req[j].we    = 1'($urandom_range(0, 1));
      pend_req[j].addr  = addr;
      pend_req[j].wdata = $urandom;
   endtask

   // One clock cycle: check registered outputs, play the tree, drive masters,
   // then check the combinational grant and advance the model.
   task automatic cycle_step();
      bit hv, tv;
      logic [31:0] hd;
      int g;
      @(posedge clk);
      #1;
      cyc++;
      if (issue_req.exists(cyc)) begin
         check("host_req.valid", 64'(host_req.valid), 64'(1));
         check("host_req.we",    64'(host_req.we),    64'(issue_req[cyc].we));
         check("host_req.addr",  64'(host_req.addr),  64'(issue_req[cyc].addr));
         check("host_req.wdata", 64'(host_req.wdata), 64'(issue_req[cyc].wdata));
      end else begin
         check("host_req.valid", 64'(host_req.valid), 64'(0));
      end
      for (int j = 0; j < N; j++) begin
         check($sformatf("mst_res[%0d].valid", j), 64'(mst_res[j].valid),
               64'(exp_res_vld && exp_res_id == j));
         if (exp_res_vld && exp_res_id == j)
            check($sformatf("mst_res[%0d].rdata", j), 64'(mst_res[j].rdata), 64'(exp_res_data));
      end
      check("err_unexp", 64'(err_unexp), 64'(exp_unexp));
      check("err_lost",  64'(err_lost),  64'(exp_lost));

      // Tree: answer each request presented now exactly L cycles later.
      if (issue_req.exists(cyc)) begin
         if (withhold) withhold = 1'b0;
         else tree_rdata[cyc+L] = (issue_req[cyc].addr == 32'h40) ? 32'hABCD : $urandom;
      end
      hv = 1'b0;
      hd = '0;
      if (tree_rdata.exists(cyc)) begin
         hv = 1'b1;
         hd = tree_rdata[cyc];
         tree_rdata.delete(cyc);
      end else if (inject_now) begin
         hv = 1'b1;
         hd = $urandom;
      end
      inject_now     = 1'b0;
      host_res.valid = hv;
      host_res.rdata = hd;

      // Expected routing and error flags for the next cycle.
      tv           = issue_req.exists(cyc - L);
      exp_res_vld  = hv && tv;
      exp_res_id   = tv ? issue_id[cyc-L] : 0;
      exp_res_data = hd;
      if (hv && !tv) exp_unexp = 1'b1;
      if (tv && !hv) exp_lost  = 1'b1;

      for (int j = 0; j < N; j++) begin
         mst_req[j]       = pend_req[j];
         mst_req[j].valid = pend[j];
      end
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (mdl_ptr + k) % N;
         if (g < 0 && pend[idx]) g = idx;
      end
      check("mst_gnt", 64'(mst_gnt), (g >= 0) ? (64'(1) << g) : 64'(0));
      if (g >= 0) begin
         issue_req[cyc+1] = pend_req[g];
         issue_id[cyc+1]  = g;
         mdl_ptr          = (g + 1) % N;
         pend[g]          = 1'b0;
         gnt_log.push_back(g);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle_step();
   endtask

   // Assert reset between edges, check the forced outputs, release later.
   task automatic do_reset(input int hold);
      for (int j = 0; j < N; j++) begin
         pend[j]     = 1'b0;
         pend_req[j] = '0;
         mst_req[j]  = '0;
      end
      host_res = '0;
      rst_n    = 1'b0;
      #1;
      check("rst host_req.valid", 64'(host_req.valid), 64'(0));
      for (int j = 0; j < N; j++)
         check($sformatf("rst mst_res[%0d].valid", j), 64'(mst_res[j].valid), 64'(0));
      check("rst err_unexp", 64'(err_unexp), 64'(0));
      check("rst err_lost",  64'(err_lost),  64'(0));
      issue_req.delete();
      issue_id.delete();
      tree_rdata.delete();
      withhold    = 1'b0;
      inject_now  = 1'b0;
      exp_res_vld = 1'b0;
      exp_unexp   = 1'b0;
      exp_lost    = 1'b0;
      mdl_ptr     = 0;
      repeat (hold) @(posedge clk);
      cyc += hold;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int issued;
      rst_n = 1'b0;
      for (int j = 0; j < N; j++) begin
         mst_req[j]  = '0;
         pend_req[j] = '0;
         pend[j]     = 1'b0;
      end
      host_res = '0;
      #2;
      do_reset(2);

      // 1: idle after reset, everything stays quiet.
      idle(40);

      // 2: master 2 alone, addr 0x40; response lands L+2 cycles after grant.
      new_req(2, 32'h40);
      cycle_step();
      check("t2 grant", 64'(gnt_log[$]), 64'(2));
      t_mark = cyc;
      idle(L + 2);
      check("t2 latency", 64'(cyc - t_mark), 64'(L + 2));
      check("t2 mst_res[2].valid", 64'(mst_res[2].valid), 64'(1));
      check("t2 mst_res[2].rdata", 64'(mst_res[2].rdata), 64'(32'hABCD));
      check("t2 mst_res[0].valid", 64'(mst_res[0].valid), 64'(0));
      idle(2);

      // 3: master 3 alone moves the pointer to 0, then all four compete.
      new_req(3, $urandom);
      cycle_step();
      gnt_log.delete();
      for (int j = 0; j < N; j++) new_req(j, $urandom);
      issued = N;
      repeat (8) begin
         cycle_step();
         if (issued < 8) begin
            new_req(gnt_log[$], $urandom);
            issued++;
         end
      end
      for (int i = 0; i < 8; i++)
         check($sformatf("t3 grant[%0d]", i), 64'(gnt_log[i]), 64'(i % N));
      idle(L + 4);

      // 4: pointer to 2 via master 1, then masters 1 and 3 -> 3 first, then 1.
      new_req(1, $urandom);
      cycle_step();
      gnt_log.delete();
      new_req(1, $urandom);
      new_req(3, $urandom);
      idle(2);
      check("t4 first",  64'(gnt_log[0]), 64'(3));
      check("t4 second", 64'(gnt_log[1]), 64'(1));
      new_req(2, $urandom);
      new_req(3, $urandom);
      cycle_step();
      check("t4 ptr after 1", 64'(gnt_log[$]), 64'(2));
      idle(L + 4);

      // 5a: unsolicited response sets a sticky err_unexp.
      inject_now = 1'b1;
      cycle_step();
      cycle_step();
      check("t5 err_unexp rise", 64'(err_unexp), 64'(1));
      idle(10);
      check("t5 err_unexp sticky", 64'(err_unexp), 64'(1));
      do_reset(2);
      // 5b: withheld response sets err_lost.
      withhold = 1'b1;
      new_req(0, $urandom);
      idle(L + 4);
      check("t5 err_lost", 64'(err_lost), 64'(1));
      check("t5 no err_unexp", 64'(err_unexp), 64'(0));

      // 6: reset with five requests in flight; flushed and restarted cleanly.
      do_reset(2);
      for (int j = 0; j < N; j++) new_req(j, $urandom);
      idle(N);
      new_req(1, $urandom);
      idle(3);
      do_reset(3);
      idle(L + 4);
      gnt_log.delete();
      new_req(3, $urandom);
      new_req(0, $urandom);
      idle(2);
      check("t6 ptr reset", 64'(gnt_log[0]), 64'(0));
      idle(L + 4);
      new_req(2, $urandom);
      cycle_step();
      t_mark = cyc;
      idle(L + 2);
      check("t6 latency", 64'(cyc - t_mark), 64'(L + 2));
      check("t6 mst_res[2].valid", 64'(mst_res[2].valid), 64'(1));

      // Random traffic with concurrent grants and deliveries.
      repeat (300) begin
         for (int j = 0; j < N; j++)
            if (!pend[j] && $urandom_range(0, 2) == 0) new_req(j, $urandom);
         cycle_step();
      end
      idle(L + 8);
      check("final err_unexp", 64'(err_unexp), 64'(0));
      check("final err_lost",  64'(err_lost),  64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
